// File: rtl/seq_div_8_bit.sv
// Sequential 8-bit unsigned restoring divider: one quotient bit per cycle, MSB first.
// Divide-by-zero completes immediately with quotient all-ones and remainder = dividend.
module seq_div_8_bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    prem_q;
  logic [W-1:0]    wdvd_q;
  logic [W-1:0]    dvs_q;
  logic [W-1:0]    quot_q;
  logic [W-1:0]    rem_q;
  logic            busy_q;
  logic            done_q;
  logic            dbz_q;

  logic [W:0]      shift_d;
  logic            qbit_d;
  logic [W-1:0]    prem_d;
  logic [W-1:0]    wdvd_d;

  // One restoring step: the 9-bit shifted remainder is compared against the divisor,
  // and the difference always fits in 8 bits when the trial subtraction succeeds.
  always_comb begin
    shift_d = {prem_q, wdvd_q[W-1]};
    qbit_d  = shift_d[W] || (shift_d[W-1:0] >= dvs_q);
    prem_d  = qbit_d ? (shift_d[W-1:0] - dvs_q) : shift_d[W-1:0];
    wdvd_d  = {wdvd_q[W-2:0], qbit_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      wdvd_q  <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            wdvd_q <= dividend;
            dvs_q  <= divisor;
            prem_q <= '0;
            cnt_q  <= '0;
            if (divisor == '0) begin
              state_q <= DONE;
              quot_q  <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          prem_q <= prem_d;
          wdvd_q <= wdvd_d;
          cnt_q  <= cnt_q + CW'(1);
          // Final iteration writes the result straight into the output registers.
          if (cnt_q == LAST_ITER) begin
            state_q <= DONE;
            cnt_q   <= '0;
            quot_q  <= wdvd_d;
            rem_q   <= prem_d;
            dbz_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_8_bit.sv
// Directed and swept self-checking bench for seq_div_8_bit using immediate assertions.
module tb_seq_div_8_bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] prev_q;
  logic [7:0] prev_r;
  logic       prev_z;

  seq_div_8_bit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where outputs are sampled and inputs driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation (optionally back-to-back from a DONE cycle) and check timing and result.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit b2b, input string tag);
    logic [7:0] eq;
    logic [7:0] er;
    logic       ez;
    if (b == 8'd0) begin
      eq = 8'hFF; er = a; ez = 1'b1;
    end else begin
      eq = a / b; er = a % b; ez = 1'b0;
    end
    if (!b2b) step();
    start = 1'b1; dividend = a; divisor = b;
    step();
    start = 1'b0; dividend = $urandom_range(0, 255); divisor = $urandom_range(0, 255);
    if (b != 8'd0) begin
      for (int i = 0; i < 8; i++) begin
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_nodone"}, done, 1'b0);
        chk({tag, "_qhold"}, quotient, prev_q);
        chk({tag, "_rhold"}, remainder, prev_r);
        chk({tag, "_zhold"}, div_by_zero, prev_z);
        step();
      end
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_z"}, div_by_zero, ez);
    prev_q = eq; prev_r = er; prev_z = ez;
  endtask

  initial begin
    int done_cnt;
    logic [7:0] dlist [12];
    dlist = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd7, 8'd10, 8'd16, 8'd127, 8'd128, 8'd200, 8'd255};
    rst_n = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    prev_q = 8'd0; prev_r = 8'd0; prev_z = 1'b0;

    #23;
    chk("rst_q", quotient, 8'd0);
    chk("rst_r", remainder, 8'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_z", div_by_zero, 1'b0);
    step();
    rst_n = 1'b1;

    run_op(8'd200, 8'd7, 1'b0, "d200_7");
    step();
    chk("done_pulse_one", done, 1'b0);

    run_op(8'd255, 8'd1, 1'b0, "d255_1");
    run_op(8'd5, 8'd9, 1'b1, "b2b_5_9");

    run_op(8'd123, 8'd0, 1'b0, "dz_123");
    run_op(8'd10, 8'd3, 1'b0, "d10_3");

    // start in the middle of CALC must be ignored
    step();
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    step();
    start = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 2) begin start = 1'b1; dividend = 8'd9; divisor = 8'd9; end
      if (k == 3) start = 1'b0;
      step();
      if (done) done_cnt++;
      if (k == 8) begin
        chk("ign_done", done, 1'b1);
        chk("ign_q", quotient, 8'd28);
        chk("ign_r", remainder, 8'd4);
      end
    end
    chk("ign_one_pulse", done_cnt, 1);
    chk("ign_back_idle", busy, 1'b0);
    prev_q = 8'd28; prev_r = 8'd4; prev_z = 1'b0;

    // reset in the middle of CALC aborts the operation
    start = 1'b1; dividend = 8'd255; divisor = 8'd255;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("abort_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_q", quotient, 8'd0);
    chk("abort_r", remainder, 8'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_z", div_by_zero, 1'b0);
    start = 1'b1; dividend = 8'd40; divisor = 8'd0;
    step(); step();
    chk("rst_ign_start_done", done, 1'b0);
    chk("rst_ign_start_busy", busy, 1'b0);
    start = 1'b0;
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (done || busy) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    prev_q = 8'd0; prev_r = 8'd0; prev_z = 1'b0;
    run_op(8'd100, 8'd10, 1'b0, "d100_10");

    for (int di = 0; di < 12; di++) begin
      for (int a = 0; a < 256; a++) begin
        run_op(8'(a), dlist[di], (a % 2) == 1, "sweep");
      end
    end
    for (int n = 0; n < 300; n++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, "rand");
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
